kypd_scanner: RTL
=================

# kypd_scanner

Scans the 4x4 Pmod keypad by driving one column low at a time and sampling the rows. It debounces full-matrix snapshots and converts each new single-key press into a 4-bit key code. Codes are queued in a small FIFO, and the PicoBlaze input-port logic reads them through a valid/ack handshake. The block sits between the keypad pins and the PicoBlaze controller, replacing per-pin debouncing of KYPD_ROW/KYPD_COL.

## Interface
Parameters:
- DWELL_CYCLES, 100000: clock cycles each column is driven (1 ms at 100 MHz); ≥4.
- DEBOUNCE_SCANS, 4: number of consecutive identical full scans required before the debounced matrix updates; ≥2.
- FIFO_DEPTH, 4: key-code queue depth; power of two.

Ports:
- clk in 1: single clock (100 MHz system clock).
- RST in 1: reset, asynchronous and active-low.
- KYPD_COL out 4: column drive. Exactly one bit is low (active column); the others are high.
- KYPD_ROW in 4: row sense, pulled up; low means pressed. Asynchronous input.
- key_code out 4: code at the FIFO head; 0 when empty.
- key_valid out 1: FIFO not empty.
- key_ack in 1: pops the head when key_valid is high.
- key_held out 1: at least one key is down in the debounced matrix.
- overflow out 1: sticky; set when a press is dropped because the FIFO is full.
- clr_overflow in 1: clears overflow.

## Operation
- **Row synchroniser:** KYPD_ROW passes through a 2-flop synchroniser, then is inverted to active-high.
- **Column sequencer:**
  - The dwell counter runs 0..DWELL_CYCLES-1.
  - On the last dwell cycle, the synchronised rows are stored into the snapshot nibble of the current column, and the column advances 0→1→2→3→0.
  - KYPD_COL is 1110, 1101, 1011, 0111 for columns 0..3.
- **Scan completion:** a full scan completes on the last dwell cycle of column 3. The 16-bit scan is {col3,col2,col1,col0} with row index as the bit within each nibble.
- **Debounce:**
  - If the completed scan equals the previous completed scan, stable_cnt increments, saturating at DEBOUNCE_SCANS-1. Otherwise stable_cnt is set to 0.
  - When stable_cnt = DEBOUNCE_SCANS-1 and scan ≠ debounced, debounced ← scan.
- **Press event:** raised on a debounced update where the new matrix has exactly one bit set and that bit was clear in the old matrix.
  - All other updates produce no event: releases, multi-key matrices, or the same key remaining down.
  - The event pushes the mapped code.
- **Key map (column, rows 0..3):**
  - col0: 1, 4, 7, 0
  - col1: 2, 5, 8, F
  - col2: 3, 6, 9, E
  - col3: A, B, C, D
- **FIFO:**
  - A push while full with no pop in the same cycle drops the code and sets overflow.
  - Push and pop in the same cycle both take effect, including when the FIFO is full.
  - key_ack while empty is ignored.
- **overflow:** clr_overflow clears it. If a drop and clr_overflow occur in the same cycle, the set wins.
- **key_held:** equals |debounced.

## Timing
- Reset values: KYPD_COL=1110, key_code=0, key_valid=0, key_held=0, overflow=0. Counters, snapshot, previous scan and debounced are all 0.
- Sampling delay: a row change at the pins is visible in the snapshot at the earliest 2 cycles after it settles. The sample point is the last dwell cycle.
- Debounce latency: the debounced update lands on the scan-completion cycle of the DEBOUNCE_SCANS-th identical scan.
- Push timing: the push occurs on the following clock edge, and key_valid/key_code are valid from the cycle after that.
- Pop timing: on key_ack sampled high with key_valid high, the next head (or 0/invalid) appears the next cycle.
- Read pacing: PicoBlaze must read key_code, then pulse key_ack for exactly one cycle per code.
- Reset mid-scan: asynchronous reset returns everything to reset values immediately, with KYPD_COL=1110. The FIFO contents are discarded.

## Structure
- Package kypd_pkg holds:
  - NUM_COLS/NUM_ROWS = 4
  - the column-drive pattern constants
  - the key-map function (col, row) → code
  - the one-hot detection helper
- Sub-module kypd_fifo: synchronous FIFO with parameterised depth and width 4, exposing push, pop, full, empty and head. It has the same clk/RST.
- Everything else stays in kypd_scanner: synchroniser, sequencer FSM, debounce and event logic.

## Test plan
All scenarios use DWELL_CYCLES=8 and DEBOUNCE_SCANS=2.
- **Reset and free-running scan:** release RST → KYPD_COL cycles 1110, 1101, 1011, 0111, changing every 8 clocks. key_valid=0, overflow=0.
- **Single key, clean press:** hold row2 low whenever column 1 is active → code 8 pushed once. key_valid rises after the second identical scan; key_held=1. Holding longer produces no second push.
- **Bounce rejection:** toggle row0 on column 3 every alternate scan for 6 scans → no push and debounced stays 0. Then hold it steady → one push of code A.
- **Two-key ghost:** press keys 5 and 9 together → no push, key_held=1. Release 9, keeping 5 → no push (5 was already down). Release all, then press 0 → push 0.
- **FIFO full/overflow:** press and release distinct keys 1, 2, 3, 4, 5 without ack → the FIFO holds 1, 2, 3, 4, code 5 is dropped and overflow=1. Ack four times → codes 1, 2, 3, 4 are read in order. Pulse clr_overflow → overflow=0.
- **Reset mid-operation:** assert RST while column 2 is active with 2 codes queued → all outputs go to reset values asynchronously. After release, scanning restarts at column 0.

Source files
------------

// File: rtl/kypd_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner.
// Column drive patterns, key map and one-hot helpers.
package kypd_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  localparam logic [3:0] COL_DRV0 = 4'b1110;
  localparam logic [3:0] COL_DRV1 = 4'b1101;
  localparam logic [3:0] COL_DRV2 = 4'b1011;
  localparam logic [3:0] COL_DRV3 = 4'b0111;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_e;

  function automatic logic [3:0] col_drive(input col_e c);
    case (c)
      COL0:    return COL_DRV0;
      COL1:    return COL_DRV1;
      COL2:    return COL_DRV2;
      default: return COL_DRV3;
    endcase
  endfunction

  // Printed legend of the Pmod keypad, indexed by {column, row}.
  function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
    case ({col, row})
      4'h0: return 4'h1;
      4'h1: return 4'h4;
      4'h2: return 4'h7;
      4'h3: return 4'h0;
      4'h4: return 4'h2;
      4'h5: return 4'h5;
      4'h6: return 4'h8;
      4'h7: return 4'hF;
      4'h8: return 4'h3;
      4'h9: return 4'h6;
      4'hA: return 4'h9;
      4'hB: return 4'hE;
      4'hC: return 4'hA;
      4'hD: return 4'hB;
      4'hE: return 4'hC;
      default: return 4'hD;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

  function automatic logic [3:0] onehot_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kypd_fifo.sv
// Small synchronous key-code queue; push and pop may coincide, even when full.
// A push while full without a pop is discarded (caller flags the drop).
import kypd_pkg::*;

module kypd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  // Count tops out at exactly 2**AW, so the MSB alone marks full.
  assign full_o  = count_q[AW];
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/kypd_scanner.sv
// Pmod 4x4 keypad scanner: column sequencer, row sync, full-matrix debounce,
// single-press detection and a key-code queue read through valid/ack.
//
// state | meaning
// COL0  | column 0 driven low (1110), rows sampled into snap[3:0]
// COL1  | column 1 driven low (1101), rows sampled into snap[7:4]
// COL2  | column 2 driven low (1011), rows sampled into snap[11:8]
// COL3  | column 3 driven low (0111), last dwell cycle completes a scan
import kypd_pkg::*;

module kypd_scanner #(
  parameter int DWELL_CYCLES   = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       RST,
  output logic [3:0] KYPD_COL,
  input  logic [3:0] KYPD_ROW,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int SW = $clog2(DEBOUNCE_SCANS);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

  logic [3:0]    row_s1_q, row_s2_q, rows_act;
  logic [DW-1:0] dwell_q;
  col_e          col_q;
  logic [3:0]    col_drv_q;
  logic [11:0]   snap_q;
  logic [15:0]   prev_q, deb_q, scan_w;
  logic [SW-1:0] stable_q, stable_d;
  logic          push_q, ovf_q;
  logic [3:0]    push_code_q, press_code, hit_idx;
  logic          last_dwell, scan_done, deb_upd, press, drop;
  logic          fifo_full, fifo_empty;
  logic [3:0]    fifo_head;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= KYPD_ROW;
      row_s2_q <= row_s1_q;
    end
  end

  assign rows_act   = ~row_s2_q;
  assign last_dwell = (dwell_q == DWELL_LAST);
  assign scan_done  = last_dwell && (col_q == COL3);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      dwell_q   <= '0;
      col_q     <= COL0;
      col_drv_q <= col_drive(COL0);
      snap_q    <= '0;
    end else if (last_dwell) begin
      dwell_q <= '0;
      case (col_q)
        COL0: begin
          snap_q[3:0] <= rows_act;
          col_q       <= COL1;
          col_drv_q   <= col_drive(COL1);
        end
        COL1: begin
          snap_q[7:4] <= rows_act;
          col_q       <= COL2;
          col_drv_q   <= col_drive(COL2);
        end
        COL2: begin
          snap_q[11:8] <= rows_act;
          col_q        <= COL3;
          col_drv_q    <= col_drive(COL3);
        end
        default: begin
          col_q     <= COL0;
          col_drv_q <= col_drive(COL0);
        end
      endcase
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  // Column 3 never lands in snap_q; its rows go straight into the scan word.
  assign scan_w = {rows_act, snap_q};

  always_comb begin
    stable_d = '0;
    if (scan_w == prev_q) begin
      stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + 1'b1;
    end
  end

  assign deb_upd    = scan_done && (stable_d == STABLE_MAX) && (scan_w != deb_q);
  assign hit_idx    = onehot_index(scan_w);
  assign press_code = key_map(hit_idx[3:2], hit_idx[1:0]);
  assign press      = deb_upd && is_onehot(scan_w) && ((scan_w & deb_q) == '0);
  assign drop       = push_q && fifo_full && !key_ack;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      prev_q      <= '0;
      stable_q    <= '0;
      deb_q       <= '0;
      push_q      <= 1'b0;
      push_code_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      push_q      <= press;
      push_code_q <= press_code;
      if (scan_done) begin
        prev_q   <= scan_w;
        stable_q <= stable_d;
        if (deb_upd) deb_q <= scan_w;
      end
      if (drop)              ovf_q <= 1'b1;
      else if (clr_overflow) ovf_q <= 1'b0;
    end
  end

  kypd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk     (clk),
    .RST     (RST),
    .push_i  (push_q),
    .pop_i   (key_ack),
    .din_i   (push_code_q),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign KYPD_COL  = col_drv_q;
  assign key_valid = !fifo_empty;
  assign key_code  = fifo_empty ? 4'h0 : fifo_head;
  assign key_held  = |deb_q;
  assign overflow  = ovf_q;

endmodule
